// File: rtl/slow_to_fast_bridge.sv
// Carries words produced on a divided-rate clock enable into a full-rate
// valid/ready stream through a small first-word-fall-through FIFO.
module slow_to_fast_bridge #(
  parameter int WIDTH = 32,
  parameter int DIV   = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk1x,
  input  logic                       rst,
  output logic                       ce_slow,
  input  logic                       s_valid,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    ce_slow   = (div_cnt_q == CW'(DIV-1));
    full      = (level_q == LW'(DEPTH));
    pop       = (level_q != '0) & m_ready;
    push      = ce_slow & s_valid & (!full | pop);
    drop      = ce_slow & s_valid & full & !pop;
    div_cnt_d = ce_slow ? '0 : div_cnt_q + 1'b1;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // push and pop together on a full FIFO leave level unchanged
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk1x) begin
    if (rst) begin
      div_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk1x) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign m_valid  = (level_q != '0);
  assign m_data   = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_slow_to_fast_bridge.sv
// Scoreboard bench for slow_to_fast_bridge: DIV=2 instance for data paths,
// DIV=5 instance for divider timing and off-strobe input rejection.
module tb_slow_to_fast_bridge;

  logic clk1x = 1'b0;
  always #5 clk1x = ~clk1x;

  logic        rst, s_valid, m_ready;
  logic [31:0] s_data;
  logic        ce_slow, m_valid, overflow;
  logic [31:0] m_data;
  logic [2:0]  level;

  logic        rst5, s_valid5, m_ready5;
  logic [31:0] s_data5;
  logic        ce5, m_valid5, overflow5;
  logic [31:0] m_data5;
  logic [2:0]  level5;

  slow_to_fast_bridge #(.WIDTH(32), .DIV(2), .DEPTH(4)) u2 (
    .clk1x(clk1x), .rst(rst), .ce_slow(ce_slow),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .overflow(overflow)
  );

  slow_to_fast_bridge #(.WIDTH(32), .DIV(5), .DEPTH(4)) u5 (
    .clk1x(clk1x), .rst(rst5), .ce_slow(ce5),
    .s_valid(s_valid5), .s_data(s_data5),
    .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5),
    .level(level5), .overflow(overflow5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int cnt2    = 0;
  int cnt5    = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference divider counters
  always @(posedge clk1x) begin
    cnt2 <= rst  ? 0 : (cnt2 == 1 ? 0 : cnt2 + 1);
    cnt5 <= rst5 ? 0 : (cnt5 == 4 ? 0 : cnt5 + 1);
  end

  // monitor: divider strobes and scoreboard pops
  always @(negedge clk1x) begin
    if (chk_en) begin
      check("ce_slow_div2", {31'd0, ce_slow}, {31'd0, cnt2 == 1});
      check("ce_slow_div5", {31'd0, ce5}, {31'd0, cnt5 == 4});
      check("m_valid_div5", {31'd0, m_valid5}, 32'd0);
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected none", m_data);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk1x);
    #1;
  endtask

  task automatic to_ce();
    int n = 0;
    while (cnt2 != 1 && n < 10) begin
      step();
      n++;
    end
    if (cnt2 != 1) check("to_ce_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] d, input bit expect_acc);
    to_ce();
    s_valid = 1'b1;
    s_data  = d;
    if (expect_acc) exp_q.push_back(d);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    rst5 = 1'b1; s_valid5 = 1'b0; s_data5 = '0; m_ready5 = 1'b0;
    step();
    chk_en = 1;
    step();
    step();
    check("rst_ce", {31'd0, ce_slow}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    rst = 1'b0;
    check("ce_cycle0", {31'd0, ce_slow}, 32'd0);
    step();
    check("ce_cycle1", {31'd0, ce_slow}, 32'd1);

    // streaming with consumer always ready
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_word(i, 1);
      check("stream_level", {29'd0, level}, 32'd1);
      check("stream_m_valid", {31'd0, m_valid}, 32'd1);
    end
    s_valid = 1'b0;
    step();
    step();
    check("stream_level_end", {29'd0, level}, 32'd0);
    check("stream_overflow", {31'd0, overflow}, 32'd0);
    check("stream_q_empty", exp_q.size(), 32'd0);

    // fill under back-pressure
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h10 + i, 1);
    check("fill_level", {29'd0, level}, 32'd4);
    check("fill_overflow", {31'd0, overflow}, 32'd0);

    // full with simultaneous push and pop
    to_ce();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hA5;
    exp_q.push_back(32'hA5);
    step();
    m_ready = 1'b0;
    check("fullpp_level", {29'd0, level}, 32'd4);
    check("fullpp_overflow", {31'd0, overflow}, 32'd0);

    // full with push and no pop: dropped
    push_word(32'h77, 0);
    check("drop_overflow", {31'd0, overflow}, 32'd1);
    check("drop_level", {29'd0, level}, 32'd4);

    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_q_empty", exp_q.size(), 32'd0);
    step();
    step();
    check("drain_level", {29'd0, level}, 32'd0);
    check("drain_m_valid", {31'd0, m_valid}, 32'd0);
    check("drain_overflow_sticky", {31'd0, overflow}, 32'd1);

    // mid-operation reset with a simultaneous push
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h20 + i, 1);
    check("pre_rst_level", {29'd0, level}, 32'd3);
    check("pre_rst_overflow", {31'd0, overflow}, 32'd1);
    to_ce();
    s_valid = 1'b1;
    s_data  = 32'h99;
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    s_valid = 1'b0;
    check("post_rst_level", {29'd0, level}, 32'd0);
    check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("post_rst_overflow", {31'd0, overflow}, 32'd0);
    check("post_rst_ce0", {31'd0, ce_slow}, 32'd0);
    step();
    check("post_rst_ce1", {31'd0, ce_slow}, 32'd1);
    step();
    check("post_rst_no_write", {31'd0, m_valid}, 32'd0);

    // DIV=5: s_valid toggles only off the strobe
    rst5 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_valid5 = (cnt5 != 4) ? ~s_valid5 : 1'b0;
      s_data5  = 32'h100 + i;
      step();
    end
    check("div5_level", {29'd0, level5}, 32'd0);
    check("div5_overflow", {31'd0, overflow5}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slow_to_fast_bridge.md
# slow_to_fast_bridge

Single-clock bridge that carries data produced at a divided rate into a full-rate valid/ready stream. The divided rate is a clock-enable strobe (`ce_slow`) generated inside the block, not a derived clock, so producer and consumer share `clk1x` and no delta-cycle ordering hazard exists between them. The block sits between slow-rate producer logic that is qualified by `ce_slow` and any full-rate consumer. A small first-word-fall-through FIFO absorbs consumer back-pressure.

## Interface
- `WIDTH`, 32: data width in bits.
- `DIV`, 2: divide ratio, ≥2; one `ce_slow` pulse every `DIV` cycles.
- `DEPTH`, 4: FIFO entries, power of 2, ≥2.

- `clk1x`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce_slow`  out  1  slow-rate enable; high one cycle in every `DIV`.
- `s_valid`  in  1  producer word valid; sampled only when `ce_slow`=1.
- `s_data`  in  `WIDTH`  producer word; sampled only when `ce_slow`=1.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accept.
- `m_data`  out  `WIDTH`  head-of-FIFO word; valid while `m_valid`=1.
- `level`  out  `$clog2(DEPTH+1)`  current occupancy.
- `overflow`  out  1  sticky; set when a slow word is dropped.

## Operation
- Divider: register `div_cnt` counts 0..`DIV`-1 and wraps. `ce_slow` = (`div_cnt`==`DIV`-1). This is a combinational decode of a registered count, so it is glitch-free relative to `clk1x`.
- Push: push = `ce_slow` & `s_valid` & (!full | pop). The word is written at `wr_ptr`, then `wr_ptr`++ (mod `DEPTH`).
- Drop: when `ce_slow` & `s_valid` & full & !pop, the word is discarded and `overflow` is set to 1. It stays 1 until `rst`.
- Pop: pop = `m_valid` & `m_ready`. `rd_ptr`++ (mod `DEPTH`).
- `m_valid` = (`level`≠0). `m_data` = mem[`rd_ptr`], first-word-fall-through. `m_data` is don't-care while `m_valid`=0.
- `level` next value = `level` + push − pop. Full = (`level`==`DEPTH`). Pointers carry no extra wrap bit; `level` disambiguates full from empty.
- `s_valid`/`s_data` are ignored on cycles with `ce_slow`=0. The producer holds them across the whole slow period.
- The slow side has no back-pressure. The producer must not rely on acceptance. Loss is reported only through `overflow`.
- Reset (any cycle, including mid-transfer): `div_cnt`=0, `wr_ptr`=`rd_ptr`=0, `level`=0, `overflow`=0. All FIFO contents are discarded. Memory contents need not be cleared.

## Timing
- Reset values: `ce_slow`=0 (because `div_cnt`=0), `m_valid`=0, `level`=0, `overflow`=0. `m_data` is X/don't-care.
- First `ce_slow` occurs `DIV`-1 cycles after the first cycle with `rst`=0. Subsequent pulses follow every `DIV` cycles.
- Push-to-output latency is 1 cycle. A word accepted on edge t gives `m_valid`=1 and that `m_data` from t+1.
- Pop takes effect on the edge. The next word, or `m_valid`=0, is visible the following cycle.
- Empty with simultaneous push: no pop is possible because `m_valid`=0. `level` becomes 1.
- Full with simultaneous push and pop: both occur, `level` stays `DEPTH`, no overflow.
- Full with push and no pop: drop, `overflow` rises on the same edge, `level` stays `DEPTH`.
- `rst` asserted together with push or pop: reset wins, and no write is retained.
- Sustained throughput is 1 word per `DIV` cycles. The consumer may stall up to `DEPTH`·`DIV` cycles from empty without loss.

## Test plan
- Reset/divider, `DIV`=2: release `rst` → `ce_slow` high on cycles 1, 3, 5, …; `m_valid`=0, `level`=0, `overflow`=0 before the first push.
- Streaming, `m_ready`=1, `s_valid`=1, `s_data`=0,1,2,… each slow period → `m_data` emits 0,1,2,… in order, each one cycle after its `ce_slow` edge; `level` ≤1; `overflow`=0.
- Back-pressure fill, `DEPTH`=4, `m_ready`=0 → after 4 pushes `level`=4. The 5th push sets `overflow`=1 and is dropped. Releasing `m_ready` yields exactly 4 words, in order.
- Full with simultaneous push/pop: with `level`=4, assert `m_ready`=1 on a `ce_slow` cycle with `s_data`=0xA5 → `level` stays 4, `overflow` stays 0, and 0xA5 appears as the last drained word.
- Mid-operation reset: with `level`=3 and `overflow`=1, pulse `rst` for 1 cycle on a `ce_slow` cycle → next cycle `level`=0, `m_valid`=0, `overflow`=0; next `ce_slow` occurs `DIV`-1 cycles after `rst` falls.
- `DIV`=5 with `s_valid` toggling on non-`ce_slow` cycles only → no pushes, `level` stays 0.
